// File: rtl/shift_panel_pkg.sv
// shift_panel_pkg: shared mode encoding and mode sequencing for shift_panel
//   MODE_W    - fixed width of the mode field
//   mode_t    - MANUAL / AUTO_L / AUTO_R
//   next_mode - mode-key cycling order
package shift_panel_pkg;
    localparam int MODE_W = 2;
    typedef enum logic [MODE_W-1:0] {
        MANUAL = 2'd0,
        AUTO_L = 2'd1,
        AUTO_R = 2'd2
    } mode_t;
    function automatic mode_t next_mode(input mode_t m);
        return m == MANUAL ? AUTO_L : m == AUTO_L ? AUTO_R : MANUAL;
    endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronizer, debouncer and press detector for one active-low key
//   clk   - system clock
//   rst   - asynchronous active-high reset
//   key   - raw active-low key
//   level - debounced key level (1 = released)
//   press - one-cycle pulse on debounced 1->0
module key_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(DEB_CYCLES);
    logic s1_q, s2_q, stable_q, last_q, press_q;
    logic [CW-1:0] cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q     <= 1'b1;
            s2_q     <= 1'b1;
            stable_q <= 1'b1;
            last_q   <= 1'b1;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q    <= key;
            s2_q    <= s1_q;
            last_q  <= stable_q;
            // registered edge detect: pulse lands one clock after the stable flip
            press_q <= last_q & ~stable_q;
            if (s2_q == stable_q)
                cnt_q <= '0;
            else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                cnt_q    <= '0;
                stable_q <= s2_q;
            end else
                cnt_q <= cnt_q + 1'b1;
        end
    end
    assign level = stable_q;
    assign press = press_q;
endmodule

// File: rtl/shift_panel.sv
// shift_panel: key-driven LED shift register with manual and timed auto-shift modes
//   clk       - system clock
//   rst       - asynchronous active-high reset
//   key_clr   - clear key (active-low raw)
//   key_left  - shift-left key (active-low raw)
//   key_right - shift-right key (active-low raw)
//   key_arm   - arm qualifier, debounced level (active-low raw)
//   key_mode  - mode-cycle key (active-low raw)
//   sw_in0    - fill bit for left shift
//   sw_in1    - fill bit for right shift
//   sw_rot    - 1 = rotate instead of fill
//   seq       - LED drive, optionally bit-reversed data
//   mode      - current mode
module shift_panel
    import shift_panel_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEB_CYCLES  = 16,
    parameter int STEP_CYCLES = 1000000,
    parameter int REVERSE_OUT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_clr,
    input  logic             key_left,
    input  logic             key_right,
    input  logic             key_arm,
    input  logic             key_mode,
    input  logic             sw_in0,
    input  logic             sw_in1,
    input  logic             sw_rot,
    output logic [WIDTH-1:0] seq,
    output logic [1:0]       mode
);
    localparam int TW = $clog2(STEP_CYCLES);
    // key index: 0 arm, 1 clr, 2 left, 3 right, 4 mode
    logic [4:0] keys, level_w, press_w;
    logic level_unused;
    assign keys = {key_mode, key_right, key_left, key_clr, key_arm};
    for (genvar g = 0; g < 5; g++) begin : g_key
        key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key (
            .clk(clk),
            .rst(rst),
            .key(keys[g]),
            .level(level_w[g]),
            .press(press_w[g])
        );
    end
    assign level_unused = ^{level_w[4:1], press_w[0]};
    logic [WIDTH-1:0] data_q, shl_data, shr_data, rev_data;
    logic [TW-1:0]    timer_q;
    mode_t            mode_q;
    logic             manual, armed, tc;
    assign manual   = mode_q == MANUAL;
    assign armed    = manual & ~level_w[0];
    assign tc       = !manual && timer_q == TW'(STEP_CYCLES - 1);
    assign shl_data = {data_q[WIDTH-2:0], sw_rot ? data_q[WIDTH-1] : sw_in0};
    assign shr_data = {sw_rot ? data_q[0] : sw_in1, data_q[WIDTH-1:1]};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            mode_q  <= MANUAL;
            timer_q <= '0;
        end else begin
            timer_q <= manual || tc ? '0 : timer_q + 1'b1;
            if (press_w[1]) begin
                data_q  <= '0;
                mode_q  <= MANUAL;
                timer_q <= '0;
            end else if (press_w[4]) begin
                mode_q  <= next_mode(mode_q);
                timer_q <= '0;
            end else if (armed && press_w[2])
                data_q <= shl_data;
            else if (armed && press_w[3])
                data_q <= shr_data;
            else if (tc)
                data_q <= mode_q == AUTO_L ? shl_data : shr_data;
        end
    end
    always_comb begin
        for (int i = 0; i < WIDTH; i++)
            rev_data[i] = data_q[WIDTH-1-i];
    end
    assign seq  = REVERSE_OUT != 0 ? rev_data : data_q;
    assign mode = mode_q;
endmodule

// File: tb/tb_shift_panel.sv
// tb_shift_panel: randomized self-checking bench for shift_panel against a behavioural model
module tb_shift_panel;
    logic clk = 1'b0;
    logic rst;
    logic key_clr, key_left, key_right, key_arm, key_mode;
    logic sw_in0, sw_in1, sw_rot;
    logic [7:0] seq;
    logic [1:0] mode;
    int checks = 0;
    int errors = 0;
    int md = 0;
    int mm = 0;
    bit arm_m = 0;

    shift_panel #(.WIDTH(8), .DEB_CYCLES(4), .STEP_CYCLES(8), .REVERSE_OUT(1)) dut (
        .clk(clk), .rst(rst),
        .key_clr(key_clr), .key_left(key_left), .key_right(key_right),
        .key_arm(key_arm), .key_mode(key_mode),
        .sw_in0(sw_in0), .sw_in1(sw_in1), .sw_rot(sw_rot),
        .seq(seq), .mode(mode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int rev8(input int d);
        int r = 0;
        for (int i = 0; i < 8; i++)
            if (d[i]) r |= 1 << (7 - i);
        return r;
    endfunction

    function automatic int lstep(input int d, input bit rot, input bit fill);
        int f = rot ? int'(d[7]) : int'(fill);
        return ((d << 1) | f) & 255;
    endfunction

    function automatic int rstep(input int d, input bit rot, input bit fill);
        int f = rot ? int'(d[0]) : int'(fill);
        return (d >> 1) | (f << 7);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_seq"}, seq, rev8(md));
        chk({tag, "_mode"}, mode, mm);
    endtask

    task automatic set_arm(input bit a);
        key_arm = ~a;
        arm_m = a;
        repeat (8) tick;
    endtask

    // clean press of any key combination in MANUAL, model updated afterwards
    task automatic press(input bit c, input bit l, input bit r);
        key_clr = ~c;
        key_left = ~l;
        key_right = ~r;
        repeat (8) tick;
        key_clr = 1'b1;
        key_left = 1'b1;
        key_right = 1'b1;
        repeat (8) tick;
        if (c) begin
            md = 0;
            mm = 0;
        end else if (mm == 0 && arm_m) begin
            if (l) md = lstep(md, sw_rot, sw_in0);
            else if (r) md = rstep(md, sw_rot, sw_in1);
        end
    endtask

    initial begin
        {key_clr, key_left, key_right, key_arm, key_mode} = 5'b11111;
        {sw_in0, sw_in1, sw_rot} = 3'b000;
        rst = 1'b1;
        repeat (3) tick;
        chk("reset_seq", seq, 0);
        chk("reset_mode", mode, 0);
        rst = 1'b0;
        repeat (3) tick;
        check_state("after_reset");

        set_arm(1);
        sw_in0 = 1'b1;
        repeat (3) press(0, 1, 0);
        chk("left3_seq", seq, 8'hE0);
        check_state("left3");

        key_left = 1'b0;
        repeat (2) tick;
        key_left = 1'b1;
        tick;
        key_left = 1'b0;
        repeat (7) tick;
        chk("bounce_early", seq, rev8(md));
        tick;
        md = lstep(md, 0, 1);
        chk("bounce_step", seq, rev8(md));
        repeat (2) tick;
        key_left = 1'b1;
        repeat (10) tick;
        check_state("bounce_once");

        press(1, 0, 0);
        sw_rot = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            sw_in0 = (i == 7 || i == 0);
            press(0, 1, 0);
        end
        chk("build81", seq, 8'h81);
        sw_rot = 1'b1;
        press(0, 0, 1);
        chk("rot_right_armed", seq, rev8(8'hC0));
        press(0, 1, 0);
        check_state("rot_left_back");
        set_arm(0);
        press(0, 0, 1);
        chk("right_unarmed", seq, 8'h81);
        set_arm(1);

        for (int n = 0; n < 40; n++) begin
            int op;
            op = $urandom_range(0, 4);
            sw_in0 = 1'($urandom);
            sw_in1 = 1'($urandom);
            sw_rot = 1'($urandom);
            case (op)
                0: press(0, 1, 0);
                1: press(0, 0, 1);
                2: press(0, 1, 1);
                3: press(1, 0, 0);
                default: set_arm(!arm_m);
            endcase
            check_state("rand");
        end

        set_arm(1);
        press(1, 0, 0);
        sw_rot = 1'b0;
        sw_in0 = 1'b1;
        press(0, 1, 0);
        sw_rot = 1'b1;
        key_mode = 1'b0;
        repeat (8) tick;
        key_mode = 1'b1;
        chk("auto_l_mode", mode, 1);
        repeat (7) tick;
        chk("auto_l_pre", seq, rev8(8'h01));
        tick;
        chk("auto_l_first", seq, rev8(8'h02));
        repeat (55) tick;
        chk("auto_l_63", seq, rev8(8'h80));
        tick;
        chk("auto_l_64", seq, rev8(8'h01));

        key_mode = 1'b0;
        repeat (8) tick;
        key_mode = 1'b1;
        chk("auto_r_mode", mode, 2);
        chk("auto_r_entry", seq, rev8(8'h01));
        repeat (7) tick;
        chk("auto_r_pre", seq, rev8(8'h01));
        tick;
        chk("auto_r_first", seq, rev8(8'h80));
        key_clr = 1'b0;
        key_left = 1'b0;
        repeat (8) tick;
        chk("clr_left_seq", seq, 0);
        chk("clr_left_mode", mode, 0);
        repeat (4) tick;
        chk("clr_left_hold", seq, 0);
        key_clr = 1'b1;
        key_left = 1'b1;
        repeat (8) tick;
        md = 0;
        mm = 0;
        check_state("clr_left_end");

        sw_rot = 1'b0;
        sw_in0 = 1'b1;
        press(0, 1, 0);
        check_state("pre_rst");
        key_mode = 1'b0;
        repeat (8) tick;
        key_mode = 1'b1;
        repeat (5) tick;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_seq", seq, 0);
        chk("async_rst_mode", mode, 0);
        repeat (2) tick;
        rst = 1'b0;
        md = 0;
        mm = 0;
        for (int n = 0; n < 20; n++) begin
            tick;
            check_state("post_rst");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
